// File: rtl/pll_mgmt_pkg.sv
// Shared constants and types for the PLL reconfiguration management slave.
package pll_mgmt_pkg;

    localparam int unsigned PLL_TIMER_W = 16;

    localparam logic [5:0] PLL_A_MODE   = 6'd0;
    localparam logic [5:0] PLL_A_STATUS = 6'd1;
    localparam logic [5:0] PLL_A_START  = 6'd2;
    localparam logic [5:0] PLL_A_N      = 6'd3;
    localparam logic [5:0] PLL_A_M      = 6'd4;
    localparam logic [5:0] PLL_A_K      = 6'd7;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StLocking
    } pll_mgmt_state_t;

endpackage

// File: rtl/pll_mgmt_timer.sv
// Loadable down-counter; o_expire is high while the count equals 1.
module pll_mgmt_timer
    import pll_mgmt_pkg::*;
#(
    parameter logic [PLL_TIMER_W-1:0] RESET_VAL = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [PLL_TIMER_W-1:0] i_load_val,
    output logic                   o_expire
);

    logic [PLL_TIMER_W-1:0] r_count;

    // Saturates at zero so an idle timer never re-fires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == PLL_TIMER_W'(1));

endmodule

// File: rtl/pll_mgmt_slave.sv
// Avalon-MM responder modelling the PLL reconfiguration handshake: shadows N/M/K,
// stalls for a busy window after START, applies the snapshot and models relock.
module pll_mgmt_slave
    import pll_mgmt_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 64,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter logic [31:0] K_RESET     = 32'd1503512573
) (
    input  logic        mgmt_clk,
    input  logic        reset_n,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic [31:0] active_k,
    output logic [17:0] active_m,
    output logic [17:0] active_n,
    output logic        locked,
    output logic        reconfig_done
);

    localparam logic [PLL_TIMER_W-1:0] BUSY_LD = PLL_TIMER_W'(BUSY_CYCLES);
    localparam logic [PLL_TIMER_W-1:0] LOCK_LD = PLL_TIMER_W'(LOCK_CYCLES);

    pll_mgmt_state_t r_state, w_state_d;

    logic        r_mode, r_err, r_waitreq, r_locked, r_done;
    logic [31:0] r_rdata;
    logic [17:0] r_shadow_n, r_shadow_m, r_pend_n, r_pend_m, r_active_n, r_active_m;
    logic [31:0] r_shadow_k, r_pend_k, r_active_k;

    logic                   w_wr_acc, w_rd_acc, w_start, w_expire;
    logic                   w_tmr_load;
    logic [PLL_TIMER_W-1:0] w_tmr_val;
    logic                   w_mode_d, w_err_d, w_waitreq_d, w_locked_d, w_done_d;
    logic                   w_snap, w_apply;
    logic [31:0]            w_rdata;

    // A simultaneous read and write is treated as a write only.
    assign w_wr_acc = mgmt_write & ~r_waitreq;
    assign w_rd_acc = mgmt_read & ~mgmt_write & ~r_waitreq;
    assign w_start  = w_wr_acc && (mgmt_address == PLL_A_START);

    pll_mgmt_timer #(
        .RESET_VAL (LOCK_LD)
    ) u_timer (
        .i_clk      (mgmt_clk),
        .i_rst_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge mgmt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StLocking;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = BUSY_LD;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d  = StBusy;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = BUSY_LD;
                end
            end
            StBusy: begin
                if (w_expire) begin
                    w_state_d  = StLocking;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = LOCK_LD;
                end
            end
            StLocking: begin
                if (w_expire) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StLocking;
        endcase
    end

    always_comb begin
        w_mode_d = r_mode;
        if (w_wr_acc && (mgmt_address == PLL_A_MODE)) begin
            w_mode_d = mgmt_writedata[0];
        end
        w_snap  = (r_state == StIdle) && w_start;
        w_apply = (r_state == StBusy) && w_expire;
        // Set beats clear when a rejected START and a STATUS read coincide.
        w_err_d = (w_start && (r_state != StIdle)) |
                  (r_err & ~(w_rd_acc && (mgmt_address == PLL_A_STATUS)));
        w_waitreq_d = (w_state_d == StBusy) && !w_mode_d;
        w_locked_d  = (w_state_d == StIdle);
        w_done_d    = (r_state == StLocking) && w_expire;
        w_rdata     = '0;
        case (mgmt_address)
            PLL_A_MODE:   w_rdata = {31'b0, r_mode};
            PLL_A_STATUS: w_rdata = {30'b0, r_err, (r_state == StBusy)};
            PLL_A_N:      w_rdata = {14'b0, r_shadow_n};
            PLL_A_M:      w_rdata = {14'b0, r_shadow_m};
            PLL_A_K:      w_rdata = r_shadow_k;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge mgmt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode     <= 1'b0;
            r_err      <= 1'b0;
            r_waitreq  <= 1'b0;
            r_locked   <= 1'b0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
            r_shadow_n <= '0;
            r_shadow_m <= '0;
            r_shadow_k <= K_RESET;
            r_pend_n   <= '0;
            r_pend_m   <= '0;
            r_pend_k   <= K_RESET;
            r_active_n <= '0;
            r_active_m <= '0;
            r_active_k <= K_RESET;
        end else begin
            r_mode    <= w_mode_d;
            r_err     <= w_err_d;
            r_waitreq <= w_waitreq_d;
            r_locked  <= w_locked_d;
            r_done    <= w_done_d;
            if (w_wr_acc && (mgmt_address == PLL_A_N)) r_shadow_n <= mgmt_writedata[17:0];
            if (w_wr_acc && (mgmt_address == PLL_A_M)) r_shadow_m <= mgmt_writedata[17:0];
            if (w_wr_acc && (mgmt_address == PLL_A_K)) r_shadow_k <= mgmt_writedata;
            if (w_snap) begin
                r_pend_n <= r_shadow_n;
                r_pend_m <= r_shadow_m;
                r_pend_k <= r_shadow_k;
            end
            if (w_apply) begin
                r_active_n <= r_pend_n;
                r_active_m <= r_pend_m;
                r_active_k <= r_pend_k;
            end
            if (w_rd_acc) r_rdata <= w_rdata;
        end
    end

    assign mgmt_readdata    = r_rdata;
    assign mgmt_waitrequest = r_waitreq;
    assign active_k         = r_active_k;
    assign active_m         = r_active_m;
    assign active_n         = r_active_n;
    assign locked           = r_locked;
    assign reconfig_done    = r_done;

endmodule

// File: tb/tb_pll_mgmt_slave.sv
// Directed bench for pll_mgmt_slave; cycle k is the interval after the k-th rising edge.
module tb_pll_mgmt_slave;

    localparam logic [31:0] K_RST = 32'd1503512573;
    localparam logic [31:0] K_A   = 32'd3357876127;
    localparam logic [31:0] K_B   = 32'd2233385555;

    logic        mgmt_clk = 1'b0;
    logic        reset_n  = 1'b0;
    logic [5:0]  mgmt_address = '0;
    logic        mgmt_write = 1'b0;
    logic [31:0] mgmt_writedata = '0;
    logic        mgmt_read = 1'b0;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic [31:0] active_k;
    logic [17:0] active_m, active_n;
    logic        locked, reconfig_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int t0 = 0;

    pll_mgmt_slave u_dut (
        .mgmt_clk         (mgmt_clk),
        .reset_n          (reset_n),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_read        (mgmt_read),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .active_k         (active_k),
        .active_m         (active_m),
        .active_n         (active_n),
        .locked           (locked),
        .reconfig_done    (reconfig_done)
    );

    always #5 mgmt_clk = ~mgmt_clk;
    always @(posedge mgmt_clk) cyc <= cyc + 1;
    always @(negedge mgmt_clk) if (mgmt_waitrequest) wr_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge mgmt_clk);
    endtask

    // Called at a falling edge; returns the acceptance cycle and ends one cycle later.
    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, output int tacc);
        int n = 0;
        mgmt_address   = a;
        mgmt_writedata = d;
        mgmt_write     = 1'b1;
        while (mgmt_waitrequest && n < 200) begin
            @(negedge mgmt_clk);
            n++;
        end
        checks++;
        if (mgmt_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL write_timeout: addr %0d still stalled after %0d cycles", a, n);
        end
        tacc = cyc;
        @(negedge mgmt_clk);
        mgmt_write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        int n = 0;
        mgmt_address = a;
        mgmt_read    = 1'b1;
        while (mgmt_waitrequest && n < 200) begin
            @(negedge mgmt_clk);
            n++;
        end
        checks++;
        if (mgmt_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL read_timeout: addr %0d still stalled after %0d cycles", a, n);
        end
        @(negedge mgmt_clk);
        mgmt_read = 1'b0;
        d = mgmt_readdata;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge mgmt_clk);
        checks++;
        if (mgmt_waitrequest !== 1'b0 || locked !== 1'b0 || reconfig_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: wr/lk/done %b%b%b want 000",
                     mgmt_waitrequest, locked, reconfig_done);
        end
        checks++;
        if (mgmt_readdata !== 32'h0 || active_k !== K_RST || active_m !== 18'h0 ||
            active_n !== 18'h0) begin
            errors++;
            $display("FAIL reset_data: rd %h k %0d m %h n %h want 0 %0d 0 0",
                     mgmt_readdata, active_k, active_m, active_n, K_RST);
        end
        reset_n = 1'b1;
        t0 = cyc;
        wait_cyc(t0 + 1023);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reset_lock_early: locked %b want 0 at +1023", locked);
        end
        wait_cyc(t0 + 1024);
        checks++;
        if (locked !== 1'b1 || reconfig_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_lock: locked %b done %b want 1 1 at +1024", locked, reconfig_done);
        end
        wait_cyc(t0 + 1025);
        checks++;
        if (reconfig_done !== 1'b0 || active_k !== K_RST) begin
            errors++;
            $display("FAIL reset_done_pulse: done %b k %0d want 0 %0d", reconfig_done, active_k,
                     K_RST);
        end
    endtask

    task automatic test_regmap();
        logic [31:0] d;
        int t;
        bus_read(6'd7, d);
        checks++;
        if (d !== K_RST) begin errors++; $display("FAIL rb_k_reset: got %0d want %0d", d, K_RST); end
        bus_write(6'd3, 32'hFFFF_FFFF, t);
        bus_read(6'd3, d);
        checks++;
        if (d !== 32'h0003_FFFF) begin errors++; $display("FAIL rb_n_mask: got %h want 0003ffff", d); end
        bus_write(6'd4, 32'h0001_2345, t);
        bus_read(6'd4, d);
        checks++;
        if (d !== 32'h0001_2345) begin errors++; $display("FAIL rb_m: got %h want 00012345", d); end
        bus_write(6'd5, 32'hDEAD_BEEF, t);
        bus_read(6'd5, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rb_unmapped: got %h want 0", d); end
        bus_write(6'd0, 32'hFFFF_FFFF, t);
        bus_read(6'd0, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL rb_mode1: got %h want 1", d); end
        bus_write(6'd0, 32'h0, t);
        bus_read(6'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rb_status_idle: got %h want 0", d); end
        bus_read(6'd7, d);
        repeat (5) @(negedge mgmt_clk);
        checks++;
        if (mgmt_readdata !== K_RST || active_n !== 18'h0) begin
            errors++;
            $display("FAIL rd_hold: rd %0d n %h want %0d 0", mgmt_readdata, active_n, K_RST);
        end
    endtask

    task automatic test_waitreq_mode();
        logic [31:0] d;
        int t, ta;
        bus_write(6'd7, K_A, t);
        bus_write(6'd3, 32'd5, t);
        bus_write(6'd4, 32'd9, t);
        wr_cnt = 0;
        bus_write(6'd2, 32'd0, t0);
        bus_write(6'd3, 32'd7, ta);
        checks++;
        if (ta !== t0 + 65) begin
            errors++;
            $display("FAIL wr_stall_accept: accepted at +%0d want +65", ta - t0);
        end
        checks++;
        if (wr_cnt !== 64) begin errors++; $display("FAIL wr_high_cycles: got %0d want 64", wr_cnt); end
        checks++;
        if (active_k !== K_A || active_n !== 18'd5 || active_m !== 18'd9 || locked !== 1'b0) begin
            errors++;
            $display("FAIL wr_apply: k %0d n %0d m %0d lk %b want %0d 5 9 0",
                     active_k, active_n, active_m, locked, K_A);
        end
        wait_cyc(t0 + 1088);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL wr_lock_early: locked %b want 0", locked); end
        wait_cyc(t0 + 1089);
        checks++;
        if (locked !== 1'b1 || reconfig_done !== 1'b1) begin
            errors++;
            $display("FAIL wr_lock: locked %b done %b want 1 1", locked, reconfig_done);
        end
        wait_cyc(t0 + 1090);
        bus_read(6'd3, d);
        checks++;
        if (d !== 32'd7 || reconfig_done !== 1'b0) begin
            errors++;
            $display("FAIL wr_shadow_n: n %0d done %b want 7 0", d, reconfig_done);
        end
    endtask

    task automatic test_polling();
        logic [31:0] d;
        int t, t2;
        bus_write(6'd0, 32'd1, t);
        wr_cnt = 0;
        bus_write(6'd2, 32'd0, t0);
        bus_read(6'd1, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL poll_busy: status %h want 1", d); end
        bus_write(6'd7, K_B, t);
        bus_write(6'd2, 32'd0, t);
        bus_read(6'd1, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL poll_start_busy: status %h want 3", d); end
        wait_cyc(t0 + 64);
        bus_read(6'd1, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL poll_last_busy: status %h want 1", d); end
        bus_read(6'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL poll_after_busy: status %h want 0", d); end
        checks++;
        if (active_k !== K_A) begin
            errors++;
            $display("FAIL poll_pending_k: k %0d want %0d", active_k, K_A);
        end
        wait_cyc(t0 + 1089);
        checks++;
        if (locked !== 1'b1 || wr_cnt !== 0) begin
            errors++;
            $display("FAIL poll_lock: locked %b wr_cycles %0d want 1 0", locked, wr_cnt);
        end
        bus_write(6'd2, 32'd0, t2);
        wait_cyc(t2 + 64);
        checks++;
        if (active_k !== K_A) begin errors++; $display("FAIL poll2_early: k %0d want %0d", active_k, K_A); end
        wait_cyc(t2 + 65);
        checks++;
        if (active_k !== K_B) begin errors++; $display("FAIL poll2_apply: k %0d want %0d", active_k, K_B); end
        wait_cyc(t2 + 1089);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL poll2_lock: locked %b want 1", locked); end
    endtask

    task automatic test_mode_switch();
        int t;
        wr_cnt = 0;
        bus_write(6'd2, 32'd0, t0);
        wait_cyc(t0 + 10);
        bus_write(6'd0, 32'd0, t);
        checks++;
        if (mgmt_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL sw_raise: waitrequest %b want 1 at +11", mgmt_waitrequest);
        end
        wait_cyc(t0 + 65);
        checks++;
        if (mgmt_waitrequest !== 1'b0 || wr_cnt !== 54) begin
            errors++;
            $display("FAIL sw_window: waitrequest %b cycles %0d want 0 54", mgmt_waitrequest, wr_cnt);
        end
    endtask

    task automatic test_start_locking();
        logic [31:0] d;
        int t;
        wait_cyc(t0 + 100);
        bus_write(6'd2, 32'd0, t);
        bus_read(6'd1, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL lk_err_set: status %h want 2", d); end
        bus_read(6'd1, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL lk_err_clear: status %h want 0", d); end
        wait_cyc(t0 + 1088);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lk_early: locked %b want 0", locked); end
        wait_cyc(t0 + 1089);
        checks++;
        if (locked !== 1'b1 || active_k !== K_B) begin
            errors++;
            $display("FAIL lk_timing: locked %b k %0d want 1 %0d", locked, active_k, K_B);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] d;
        int t;
        bus_write(6'd7, 32'h0BAD_F00D, t);
        bus_write(6'd2, 32'd0, t0);
        wait_cyc(t0 + 30);
        checks++;
        if (mgmt_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: waitrequest %b want 1", mgmt_waitrequest);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mgmt_waitrequest !== 1'b0 || active_k !== K_RST || locked !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: wr %b k %0d lk %b want 0 %0d 0",
                     mgmt_waitrequest, active_k, locked, K_RST);
        end
        @(negedge mgmt_clk);
        reset_n = 1'b1;
        t = cyc;
        bus_read(6'd7, d);
        checks++;
        if (d !== K_RST) begin errors++; $display("FAIL rst_shadow_k: got %0d want %0d", d, K_RST); end
        wait_cyc(t + 1023);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early: locked %b want 0", locked); end
        wait_cyc(t + 1024);
        checks++;
        if (locked !== 1'b1 || reconfig_done !== 1'b1 || active_k !== K_RST || active_n !== 18'h0) begin
            errors++;
            $display("FAIL rst_relock: lk %b done %b k %0d n %h want 1 1 %0d 0",
                     locked, reconfig_done, active_k, active_n, K_RST);
        end
    endtask

    initial begin
        test_reset();
        test_regmap();
        test_waitreq_mode();
        test_polling();
        test_mode_switch();
        test_start_locking();
        test_reset_mid_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
